// File: rtl/pe_ctrl_seq.sv
// -----------------------------------------------------------------------------
// pe_ctrl_seq
//
// Command-driven sequencer for one 16-lane PE. A command from the layer
// scheduler describes a CU operation, how many feedback passes to run, where
// the feedback goes and whether the per-CU results are reduced through the
// PE's adder tree. The sequencer walks the PE through clear, compute,
// feedback and collect phases, then hands the adder-tree total (or zero for
// a per-CU command) back to the issuer over a valid/ready handshake.
//
// Parameters
//   CU_LAT     cycles a CU operation is held before its result is usable (>=1)
//   ADDER_LAT  cycles from pe_sel_adder=10 until pe_total is stable (>=1)
//   ITER_W     width of the feedback-iteration count
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   cmd_valid/ready   command handshake from the scheduler
//   cmd_op            CU operation, driven onto pe_sel_cu
//   cmd_iters         feedback passes (0 = single compute)
//   cmd_fb            feedback target: 01 = Par, 11 = In (00/10 hold operands)
//   cmd_sum           1 = reduce through the adder tree, 0 = per-CU outputs
//   pe_sel_cu         -> PE Sel_cu
//   pe_go_back        -> PE Sel_cu_go_back
//   pe_sel_adder      -> PE Sel_adder
//   pe_is_save        -> PE Is_save_cu_out
//   pe_clear          -> PE Clear_reg
//   pe_total          <- PE Out_total
//   res_valid/ready   result handshake back to the issuer
//   res_total         captured adder total (0 for per-CU commands)
//   perf_cycles       accept-to-result latency of the last command
//
// Build option
//   PE_CTRL_PERF_EN   when defined, a saturating 32-bit cycle counter measures
//                     each command and publishes it on perf_cycles; otherwise
//                     perf_cycles is tied to zero and no counter exists.
// -----------------------------------------------------------------------------
module pe_ctrl_seq #(
  parameter int CU_LAT    = 2,
  parameter int ADDER_LAT = 1,
  parameter int ITER_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ITER_W-1:0] cmd_iters,
  input  logic [1:0]        cmd_fb,
  input  logic              cmd_sum,
  output logic [1:0]        pe_sel_cu,
  output logic [1:0]        pe_go_back,
  output logic [1:0]        pe_sel_adder,
  output logic              pe_is_save,
  output logic              pe_clear,
  input  logic [31:0]       pe_total,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_total,
  output logic [31:0]       perf_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_COMPUTE,
    S_FEEDBACK,
    S_COLLECT,
    S_DRAIN,
    S_SUM_WAIT,
    S_RESULT
  } state_t;

  // Every registered control output of the sequencer, bundled so the whole
  // set can be decoded from one state in one place.
  typedef struct packed {
    logic       cmd_ready;
    logic [1:0] sel_cu;
    logic [1:0] go_back;
    logic [1:0] sel_adder;
    logic       is_save;
    logic       clear;
    logic       res_valid;
  } ctl_t;

  // One phase timer serves both multi-cycle states; it only has to count up
  // to the longer of the two latencies minus one.
  localparam int TMR_MAX = (CU_LAT > ADDER_LAT) ? CU_LAT : ADDER_LAT;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] CU_LAST    = TMR_W'(CU_LAT - 1);
  localparam logic [TMR_W-1:0] ADDER_LAST = TMR_W'(ADDER_LAT - 1);

  // Go-back encoding used while the CU results are collected.
  localparam logic [1:0] GB_COLLECT = 2'b10;

  state_t            state, state_n;
  ctl_t              ctl;
  logic [TMR_W-1:0]  tmr;
  logic              tmr_done;
  logic              accept;

  // Command fields captured at acceptance; the cmd_* inputs are ignored
  // afterwards.
  logic [1:0]        op_q;
  logic [1:0]        fb_q;
  logic              sum_q;
  logic [ITER_W-1:0] iters_rem;

  // Control values for a given state. Anything a state does not mention is 0.
  function automatic ctl_t decode(input state_t s, input logic [1:0] op,
                                  input logic [1:0] fb, input logic sum);
    ctl_t c;
    c = '0;
    case (s)
      S_IDLE:     c.cmd_ready = 1'b1;
      S_CLEAR:    c.clear     = 1'b1;
      S_COMPUTE:  c.sel_cu    = op;
      S_FEEDBACK: begin
        c.sel_cu  = op;
        c.go_back = fb;
        c.is_save = 1'b1;
      end
      S_COLLECT:  c.go_back   = GB_COLLECT;
      S_DRAIN:    c.sel_adder = sum ? 2'b10 : 2'b01;
      S_RESULT:   c.res_valid = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  assign accept = cmd_valid && cmd_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in this block gets a default before the case
    // so no path leaves it unassigned, which would otherwise infer a latch.
    state_n  = state;
    tmr_done = (state == S_SUM_WAIT) ? (tmr == ADDER_LAST) : (tmr == CU_LAST);
    case (state)
      S_IDLE:     if (accept) state_n = S_CLEAR;
      S_CLEAR:    state_n = S_COMPUTE;
      S_COMPUTE:  if (tmr_done) state_n = (iters_rem != '0) ? S_FEEDBACK : S_COLLECT;
      S_FEEDBACK: state_n = S_COMPUTE;
      S_COLLECT:  state_n = S_DRAIN;
      S_DRAIN:    state_n = sum_q ? S_SUM_WAIT : S_RESULT;
      S_SUM_WAIT: if (tmr_done) state_n = S_RESULT;
      S_RESULT:   if (res_ready) state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, registered control outputs and command/result registers
  // ---------------------------------------------------------------------------
  // Outputs are registered by decoding the *next* state, so each output word
  // lines up exactly with the state register it belongs to while staying free
  // of decode glitches at the PE boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      ctl       <= decode(S_IDLE, 2'b00, 2'b00, 1'b0);
      tmr       <= '0;
      op_q      <= '0;
      fb_q      <= '0;
      sum_q     <= 1'b0;
      iters_rem <= '0;
      res_total <= '0;
    end else begin
      // NOTE: all state updates here use non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      state <= state_n;
      ctl   <= decode(state_n, op_q, fb_q, sum_q);

      // The phase timer restarts on every state change and only advances while
      // a multi-cycle state is waiting out its latency.
      if (state_n != state) begin
        tmr <= '0;
      end else if (state == S_COMPUTE || state == S_SUM_WAIT) begin
        tmr <= tmr + TMR_W'(1);
      end

      if (accept) begin
        op_q      <= cmd_op;
        // Only 01 (Par) and 11 (In) are real feedback targets; 00 and 10 both
        // become 00 so the operands are held and the CU recomputes in place.
        fb_q      <= cmd_fb[0] ? cmd_fb : 2'b00;
        sum_q     <= cmd_sum;
        iters_rem <= cmd_iters;
      end else if (state == S_FEEDBACK && iters_rem != '0) begin
        iters_rem <= iters_rem - ITER_W'(1);
      end

      // The adder total is sampled on the edge that leaves SUM_WAIT; a per-CU
      // command reports 0 instead of whatever the adder tree happens to hold.
      if (state == S_SUM_WAIT && state_n == S_RESULT) begin
        res_total <= pe_total;
      end else if (state == S_DRAIN && state_n == S_RESULT) begin
        res_total <= '0;
      end
    end
  end

  assign cmd_ready    = ctl.cmd_ready;
  assign pe_sel_cu    = ctl.sel_cu;
  assign pe_go_back   = ctl.go_back;
  assign pe_sel_adder = ctl.sel_adder;
  assign pe_is_save   = ctl.is_save;
  assign pe_clear     = ctl.clear;
  assign res_valid    = ctl.res_valid;

  // ---------------------------------------------------------------------------
  // Optional latency counter
  // ---------------------------------------------------------------------------
`ifdef PE_CTRL_PERF_EN
  logic [31:0] perf_cnt;
  logic [31:0] perf_inc;

  assign perf_inc = (perf_cnt == 32'hFFFF_FFFF) ? perf_cnt : perf_cnt + 32'd1;

  // The counter restarts at acceptance and counts each busy cycle. The value
  // published on RESULT entry includes the increment of that same edge, which
  // makes perf_cycles equal to the accept-to-res_valid distance in cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cnt    <= '0;
      perf_cycles <= '0;
    end else begin
      if (accept) begin
        perf_cnt <= '0;
      end else if (state != S_IDLE) begin
        perf_cnt <= perf_inc;
      end

      if (state != S_RESULT && state_n == S_RESULT) begin
        perf_cycles <= perf_inc;
      end
    end
  end
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_pe_ctrl_seq.sv
// -----------------------------------------------------------------------------
// tb_pe_ctrl_seq
//
// Self-checking bench for pe_ctrl_seq. A table of commands, each with its
// hand-derived latency, result and feedback encoding, is driven one after
// another; the expected result of each command is queued when it is accepted
// and compared when res_valid appears. Hand-written sequences cover reset
// with a pending command and a reset that aborts a command mid-flight.
// -----------------------------------------------------------------------------
module tb_pe_ctrl_seq;

  localparam int CU_LAT    = 2;
  localparam int ADDER_LAT = 1;
  localparam int ITER_W    = 8;
  localparam int MAX_WAIT  = 2000;

`ifdef PE_CTRL_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ITER_W-1:0] cmd_iters;
  logic [1:0]        cmd_fb;
  logic              cmd_sum;
  logic [1:0]        pe_sel_cu;
  logic [1:0]        pe_go_back;
  logic [1:0]        pe_sel_adder;
  logic              pe_is_save;
  logic              pe_clear;
  logic [31:0]       pe_total;
  logic              res_valid;
  logic              res_ready;
  logic [31:0]       res_total;
  logic [31:0]       perf_cycles;

  pe_ctrl_seq #(
    .CU_LAT   (CU_LAT),
    .ADDER_LAT(ADDER_LAT),
    .ITER_W   (ITER_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_iters   (cmd_iters),
    .cmd_fb      (cmd_fb),
    .cmd_sum     (cmd_sum),
    .pe_sel_cu   (pe_sel_cu),
    .pe_go_back  (pe_go_back),
    .pe_sel_adder(pe_sel_adder),
    .pe_is_save  (pe_is_save),
    .pe_clear    (pe_clear),
    .pe_total    (pe_total),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_total   (res_total),
    .perf_cycles (perf_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Step to 1 ns after the next rising edge: outputs are settled there and
  // inputs changed there are far from the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] total;
    logic [31:0] perf;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [1:0]        op;
    logic [ITER_W-1:0] iters;
    logic [1:0]        fb;
    logic              sum;
    logic [31:0]       pe_total;
    logic [31:0]       exp_total;
    int                exp_lat;   // edges from acceptance to res_valid
    logic [1:0]        exp_gb;    // pe_go_back seen on every pe_is_save cycle
    int                hold;      // cycles res_ready stays low in RESULT
  } vec_t;

  vec_t vecs[7];

  task automatic check_idle_outputs(input string tag);
    check({tag, " cmd_ready"},    32'(cmd_ready),    32'd1);
    check({tag, " res_valid"},    32'(res_valid),    32'd0);
    check({tag, " pe_sel_cu"},    32'(pe_sel_cu),    32'd0);
    check({tag, " pe_go_back"},   32'(pe_go_back),   32'd0);
    check({tag, " pe_sel_adder"}, 32'(pe_sel_adder), 32'd0);
    check({tag, " pe_is_save"},   32'(pe_is_save),   32'd0);
    check({tag, " pe_clear"},     32'(pe_clear),     32'd0);
    check({tag, " res_total"},    res_total,         32'd0);
    check({tag, " perf_cycles"},  perf_cycles,       32'd0);
  endtask

  // Drive one command from the table, watch the PE control stream until the
  // result appears, then compare against the scoreboard and finish the
  // result handshake.
  task automatic run_cmd(input vec_t v, input string tag);
    int          k         = 0;
    int          n_clear   = 0;
    int          n_cu      = 0;
    int          n_save    = 0;
    int          n_gb_bad  = 0;
    int          n_collect = 0;
    int          n_add     = 0;
    int          n_add_bad = 0;
    int          n_rdy     = 0;
    exp_t        e;
    logic [31:0] held;

    res_ready = (v.hold == 0);
    pe_total  = v.pe_total;
    cmd_op    = v.op;
    cmd_iters = v.iters;
    cmd_fb    = v.fb;
    cmd_sum   = v.sum;
    cmd_valid = 1'b1;
    check({tag, " cmd_ready before accept"}, 32'(cmd_ready), 32'd1);
    tick();  // acceptance edge E0

    // Later changes on cmd_* must not affect the running command.
    cmd_valid = 1'b0;
    cmd_op    = ~v.op;
    cmd_iters = ~v.iters;
    cmd_fb    = ~v.fb;
    cmd_sum   = ~v.sum;

    e.total = v.exp_total;
    e.perf  = PERF_ON ? 32'(v.exp_lat) : 32'd0;
    sb.push_back(e);

    // k counts edges since E0; the sample after E0+k shows the state entered
    // on that edge.
    while (!res_valid && k < MAX_WAIT) begin
      if (pe_clear) n_clear++;
      if (pe_sel_cu == v.op) n_cu++;
      if (pe_is_save) begin
        n_save++;
        if (pe_go_back !== v.exp_gb || pe_sel_cu !== v.op) n_gb_bad++;
      end
      if (pe_go_back == 2'b10) n_collect++;
      if (pe_sel_adder != 2'b00) begin
        n_add++;
        if (pe_sel_adder != (v.sum ? 2'b10 : 2'b01)) n_add_bad++;
      end
      if (cmd_ready) n_rdy++;
      tick();
      k++;
    end

    if (!res_valid) begin
      check({tag, " res_valid timeout"}, 32'(res_valid), 32'd1);
      return;
    end

    check({tag, " latency"},          32'(k),         32'(v.exp_lat));
    check({tag, " clear cycles"},     32'(n_clear),   32'd1);
    check({tag, " sel_cu cycles"},    32'(n_cu),
          32'((int'(v.iters) + 1) * CU_LAT + int'(v.iters)));
    check({tag, " is_save pulses"},   32'(n_save),    32'(v.iters));
    check({tag, " feedback encode"},  32'(n_gb_bad),  32'd0);
    check({tag, " collect cycles"},   32'(n_collect), 32'd1);
    check({tag, " adder cycles"},     32'(n_add),     32'd1);
    check({tag, " adder select"},     32'(n_add_bad), 32'd0);
    check({tag, " cmd_ready busy"},   32'(n_rdy),     32'd0);

    if (sb.size() == 0) begin
      check({tag, " scoreboard underflow"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, " res_total"},   res_total,   e.total);
      check({tag, " perf_cycles"}, perf_cycles, e.perf);
    end

    held = res_total;
    for (int h = 0; h < v.hold; h++) begin
      tick();
      check({tag, " hold res_valid"}, 32'(res_valid), 32'd1);
      check({tag, " hold res_total"}, res_total,      held);
      check({tag, " hold cmd_ready"}, 32'(cmd_ready), 32'd0);
    end
    res_ready = 1'b1;
    tick();  // handshake edge
    check({tag, " res_valid after handshake"}, 32'(res_valid), 32'd0);
    check({tag, " cmd_ready after handshake"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int k;
    int n_rv;

    //            op     iters   fb     sum   pe_total       exp_total      L   gb     hold
    vecs[0] = '{2'b01, 8'd0,   2'b00, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 5,   2'b00, 0};
    vecs[1] = '{2'b10, 8'd3,   2'b11, 1'b1, 32'h0000_1234, 32'h0000_1234, 15,  2'b11, 0};
    vecs[2] = '{2'b11, 8'd1,   2'b10, 1'b0, 32'h0000_0055, 32'h0000_0000, 8,   2'b00, 0};
    vecs[3] = '{2'b01, 8'd2,   2'b01, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D, 12,  2'b01, 4};
    vecs[4] = '{2'b11, 8'd0,   2'b11, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6,   2'b11, 0};
    vecs[5] = '{2'b10, 8'd5,   2'b00, 1'b1, 32'h8000_0001, 32'h8000_0001, 21,  2'b00, 2};
    vecs[6] = '{2'b01, 8'd255, 2'b11, 1'b0, 32'h1357_9BDF, 32'h0000_0000, 770, 2'b11, 0};

    // Reset with a command already pending.
    rst       = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_iters = '0;
    cmd_fb    = 2'b00;
    cmd_sum   = 1'b0;
    res_ready = 1'b1;
    pe_total  = 32'h0000_1111;
    repeat (3) tick();
    check_idle_outputs("reset");

    // The first edge after release accepts the pending command.
    rst = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("first accept cmd_ready", 32'(cmd_ready), 32'd0);
    check("first accept pe_clear",  32'(pe_clear),  32'd1);
    k = 0;
    while (!res_valid && k < MAX_WAIT) begin
      tick();
      k++;
    end
    check("first cmd latency",   32'(k),         32'd5);
    check("first cmd res_total", res_total,      32'd0);
    tick();
    check("first cmd handshake", 32'(res_valid), 32'd0);

    // Table-driven commands.
    for (int i = 0; i < 7; i++) begin
      run_cmd(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset during the second COMPUTE of an iters=2 command.
    res_ready = 1'b1;
    pe_total  = 32'h0BAD_0BAD;
    cmd_op    = 2'b10;
    cmd_iters = 8'd2;
    cmd_fb    = 2'b01;
    cmd_sum   = 1'b1;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (4) tick();
    check("abort in second compute", 32'(pe_sel_cu), 32'd2);
    rst = 1'b0;
    #1;
    check_idle_outputs("abort");
    repeat (2) tick();
    rst  = 1'b1;
    n_rv = 0;
    for (int c = 0; c < 30; c++) begin
      if (res_valid) n_rv++;
      tick();
    end
    check("abort no result", 32'(n_rv), 32'd0);
    run_cmd(vecs[1], "after abort");

    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks",
             n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pe_ctrl_seq.md
# pe_ctrl_seq

Command-driven sequencer that generates the control stream for the 16-lane PE (`Sel_cu`, `Sel_cu_go_back`, `Sel_adder`, `Is_save_cu_out`, `Clear_reg`). It then returns the PE's adder-tree total to the issuer. It sits between the layer scheduler, which issues commands over a valid/ready handshake, and one PE instance.

## Interface
Parameters:
- `CU_LAT`, default 2: cycles a CU operation is held before its result is usable; must be ≥1.
- `ADDER_LAT`, default 1: cycles from `Sel_adder=10` until `Out_total` is stable; must be ≥1.
- `ITER_W`, default 8: width of the feedback-iteration count.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset; asynchronous, active-low.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: sequencer can accept a command.
- `cmd_op`, in, 2: CU operation, driven onto `pe_sel_cu`.
- `cmd_iters`, in, ITER_W: number of feedback passes; 0 means a single compute.
- `cmd_fb`, in, 2: feedback target, 01 = Par, 11 = In.
- `cmd_sum`, in, 1: 1 = reduce through the adder tree; 0 = per-CU outputs.
- `pe_sel_cu`, out, 2: drives the PE's `Sel_cu`.
- `pe_go_back`, out, 2: drives the PE's `Sel_cu_go_back`.
- `pe_sel_adder`, out, 2: drives the PE's `Sel_adder`.
- `pe_is_save`, out, 1: drives the PE's `Is_save_cu_out`.
- `pe_clear`, out, 1: drives the PE's `Clear_reg`.
- `pe_total`, in, 32: the PE's `Out_total`.
- `res_valid`, out, 1: result available.
- `res_ready`, in, 1: consumer accepts the result.
- `res_total`, out, 32: captured sum; 0 when `cmd_sum=0`.
- `perf_cycles`, out, 32: latency of the last command (see Configuration).

## Operation
- The FSM has the states IDLE, CLEAR, COMPUTE, FEEDBACK, COLLECT, DRAIN, SUM_WAIT and RESULT.
- All PE control outputs are decoded from the registered state. Their value is 0 unless a state listed below sets it.
- IDLE:
  - `cmd_ready=1`.
  - On `cmd_valid && cmd_ready`, latch op, iters, fb and sum, then go to CLEAR.
- CLEAR: 1 cycle, `pe_clear=1`, then go to COMPUTE.
- COMPUTE:
  - Lasts `CU_LAT` cycles with `pe_sel_cu=op`.
  - Then go to FEEDBACK if the remaining iteration count is >0; otherwise go to COLLECT.
- FEEDBACK:
  - 1 cycle with `pe_is_save=1`, `pe_go_back=fb` and `pe_sel_cu=op`.
  - Decrement the remaining iteration count, then return to COMPUTE.
  - If fb is 00 or 10, it is coerced to 00: operands are held and the CU recomputes on the same data.
- COLLECT: 1 cycle, `pe_go_back=10`.
- DRAIN: 1 cycle with `pe_sel_adder` = 10 if sum, else 01. Then go to SUM_WAIT if sum, else RESULT.
- SUM_WAIT:
  - Lasts `ADDER_LAT` cycles.
  - On the edge leaving it, `res_total <= pe_total`.
- RESULT:
  - `res_valid=1` until `res_valid && res_ready`, then go to IDLE.
  - `res_total` is held while `res_valid=1`. If sum=0, `res_total <= 0` on RESULT entry.
- The iteration counter is ITER_W wide and never wraps; the maximum count is 2^ITER_W−1.

## Timing
- Reset values:
  - state = IDLE, so `cmd_ready=1`.
  - `res_valid=0`, `res_total=0`, `perf_cycles=0`.
  - All `pe_*` outputs = 0.
- Reset asserted mid-command aborts the command immediately: all of the values above apply asynchronously, and no result is produced.
- Latency: with the command accepted at edge E0, `res_valid` rises at edge E0+L, where L = 3 + (iters+1)·CU_LAT + iters + sum·ADDER_LAT.
- `cmd_ready` drops on the cycle after acceptance. It returns to 1 on the cycle after the result handshake, so back-to-back commands are spaced by ≥1 IDLE cycle.
- `cmd_*` inputs are sampled only at acceptance; later changes are ignored.
- `res_ready` held high before RESULT: the handshake completes in the first RESULT cycle, so `res_valid` is a 1-cycle pulse.

## Configuration
- Macro: `PE_CTRL_PERF_EN`.
- Defined:
  - A 32-bit counter clears at command acceptance and increments every non-IDLE cycle.
  - It is copied into `perf_cycles` on RESULT entry, so `perf_cycles` equals L.
  - The counter saturates at 0xFFFFFFFF.
- Undefined: no counter is built and `perf_cycles` is tied to 0.

## Test plan
- Reset with `cmd_valid=1` held → `cmd_ready=1`, `res_valid=0`, all `pe_*=0`. First accept occurs on the first edge after `rst` deasserts.
- Defaults, op=01, iters=0, sum=0 → `pe_clear` high 1 cycle, `pe_sel_cu=01` for 2 cycles, `pe_go_back=10` 1 cycle, `pe_sel_adder=01` 1 cycle. `res_valid` at E0+5 with `res_total=0`.
- op=10, iters=3, fb=11, sum=1, `pe_total`=0x0000_1234 → three `pe_is_save` pulses each with `pe_go_back=11`. `res_valid` at E0+15, `res_total`=0x1234, `perf_cycles`=15 (macro on) or 0 (macro off).
- `res_ready` held low for 4 cycles in RESULT → `res_valid` and `res_total` are stable throughout; `cmd_ready=0` until 1 cycle after the handshake.
- `rst` pulsed low during the second COMPUTE of an iters=2 command → all outputs return to 0 at once and no `res_valid`. A new command afterwards completes with nominal L.
- iters=1, fb=10 → the FEEDBACK cycle drives `pe_go_back=00`, `pe_is_save=1`, and L = 3+4+1 = 8 (sum=0).
